// File: rtl/lab8_soc_pio_pkg.sv
// Shared constants for the lab8_soc multi-channel status PIO:
// per-channel register offsets and a helper for locating a channel's
// slice inside the flattened status bus.
package lab8_soc_pio_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_IRQMASK = 2'd1;
   localparam logic [1:0] REG_RSVD    = 2'd2;
   localparam logic [1:0] REG_EDGECAP = 2'd3;

   // LSB position of channel `ch` in a bus packed as {ch[N-1], ..., ch[0]}
   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/lab8_soc_status_pio_mc_if.sv
// Avalon-MM slave bus bundle for the status PIO.
// Handshake: there is no wait state. A write is accepted on the clk edge where
// chipselect is 1 and write_n is 0. readdata is registered: it reflects the
// register selected by address on the previous clk edge, whatever chipselect was.
interface lab8_soc_status_pio_mc_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/lab8_soc_pio_sync.sv
// Multi-flop input synchronizer with an optional "previous value" register
// used for rising-edge detection. When PREV_EN is 0, no prev flops are built
// and rise is a constant zero.
module lab8_soc_pio_sync #(
   parameter int WIDTH   = 64,
   parameter int STAGES  = 2,
   parameter bit PREV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] chain [STAGES];

   // Shift the raw inputs through STAGES flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= din;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign sync = chain[STAGES-1];

   generate
      if (PREV_EN) begin : g_prev
         logic [WIDTH-1:0] prev;

         // Hold last synchronized value; cleared so first post-reset 1 is an edge
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) prev <= '0;
            else          prev <= sync;
         end

         assign rise = sync & ~prev;
      end else begin : g_no_prev
         assign rise = '0;
      end
   endgenerate

endmodule

// File: rtl/lab8_soc_status_pio_mc.sv
// lab8_soc multi-channel status PIO (Avalon-MM slave, read-mostly).
// NUM_CH status buses of DATA_W bits are synchronized and exposed per channel:
//   reg0 DATA (RO), reg1 IRQMASK (RW), reg2 reserved, reg3 EDGECAP (RW1C).
// Build option STATUS_PIO_EDGE_IRQ_EN: when defined, edge capture, mask and irq
// are built; when undefined, reg1/reg3 read 0, writes are ignored and irq is 0.
module lab8_soc_status_pio_mc #(
   parameter int DATA_W      = 16,
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   lab8_soc_status_pio_mc_if.slave  bus,
   input  logic [NUM_CH*DATA_W-1:0] in_port,
   output logic                     irq
);
   import lab8_soc_pio_pkg::*;

   localparam int CH_W = ADDR_W - 2;

`ifdef STATUS_PIO_EDGE_IRQ_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic [CH_W-1:0]          ch_sel;
   logic [1:0]               reg_sel;
   logic [NUM_CH-1:0]        ch_hit;
   logic [NUM_CH*DATA_W-1:0] sync_val;
   logic [NUM_CH*DATA_W-1:0] sync_rise;
   logic [31:0]              rd_next;

   assign ch_sel  = bus.address[ADDR_W-1:2];
   assign reg_sel = bus.address[1:0];

   lab8_soc_pio_sync #(
      .WIDTH   (NUM_CH*DATA_W),
      .STAGES  (SYNC_STAGES),
      .PREV_EN (EDGE_EN)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port),
      .sync    (sync_val),
      .rise    (sync_rise)
   );

   // One-hot channel decode; out-of-range channel indices hit nothing
   always_comb begin
      ch_hit = '0;
      for (int c = 0; c < NUM_CH; c++) ch_hit[c] = (ch_sel == CH_W'(c));
   end

`ifdef STATUS_PIO_EDGE_IRQ_EN
   logic              wr_en;
   logic [DATA_W-1:0] mask_q [NUM_CH];
   logic [DATA_W-1:0] cap_q  [NUM_CH];
   logic [DATA_W-1:0] clr    [NUM_CH];
   logic              irq_next;

   assign wr_en = bus.chipselect && !bus.write_n;

   // W1C clear vector per channel, only for a write to that channel's EDGECAP
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         clr[c] = '0;
         if (wr_en && ch_hit[c] && (reg_sel == REG_EDGECAP))
            clr[c] = bus.writedata[DATA_W-1:0];
      end
   end

   // Mask writes and edge capture; a new rise overrides a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            mask_q[c] <= '0;
            cap_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && ch_hit[c] && (reg_sel == REG_IRQMASK))
               mask_q[c] <= bus.writedata[DATA_W-1:0];
            cap_q[c] <= (cap_q[c] & ~clr[c]) | sync_rise[ch_lsb(c, DATA_W) +: DATA_W];
         end
      end
   end

   // Interrupt cause: any captured edge that is unmasked on any channel
   always_comb begin
      irq_next = 1'b0;
      for (int c = 0; c < NUM_CH; c++) irq_next = irq_next | (|(cap_q[c] & mask_q[c]));
   end

   // Registered irq, one cycle behind its cause
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= irq_next;
   end
`else
   assign irq = 1'b0;
`endif

   // Bits of the bus and sync block that this build does not consume
   logic unused_bits;
   assign unused_bits = ^{bus.writedata, bus.chipselect, bus.write_n, sync_rise};

   // Read mux: zero-extended register of the addressed channel, 0 otherwise
   always_comb begin
      rd_next = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_hit[c]) begin
            case (reg_sel)
               REG_DATA:    rd_next[DATA_W-1:0] = sync_val[ch_lsb(c, DATA_W) +: DATA_W];
`ifdef STATUS_PIO_EDGE_IRQ_EN
               REG_IRQMASK: rd_next[DATA_W-1:0] = mask_q[c];
               REG_EDGECAP: rd_next[DATA_W-1:0] = cap_q[c];
`endif
               default:     ;
            endcase
         end
      end
   end

   // readdata updates every edge, independent of chipselect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus.readdata <= '0;
      else          bus.readdata <= rd_next;
   end

endmodule
